// File: rtl/pipeline_flow_types.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_flow_types
// Description : Pipeline-register flow structs and control encodings shared
//               by the EX/MEM and MEM/WB stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_flow_types;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;
    localparam logic [1:0] MEMTOREG_IMM = 2'd3;

    typedef struct packed {
        logic      MemRead;
        logic      MemWrite;
        mem_size_t MemSize;
        logic      MemUnsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] MemtoReg;
    } wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [31:0] pc_incr;
        logic [31:0] immediate;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
    } ex_mem_flow_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [31:0] pc_incr;
        logic [31:0] immediate;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
    } mem_wb_flow_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Shifts the addressed lane of a read word down to bit 0 and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import pipeline_flow_types::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  mem_size_t   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic        w_sign_b;
    logic        w_sign_h;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};
    assign w_sign_b  = ~i_unsigned & w_shifted[7];
    assign w_sign_h  = ~i_unsigned & w_shifted[15];

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SIZE_B:  o_data = {{24{w_sign_b}}, w_shifted[7:0]};
            SIZE_H:  o_data = {{16{w_sign_h}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage: variable-latency load/store bus master
//               with lane alignment, misalign trap, timeout and MEM forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import pipeline_flow_types::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  ex_mem_flow_t inflow,
    input  logic         in_valid,
    output mem_wb_flow_t outflow,
    output logic         out_valid,
    output logic         stall,
    output logic [31:0]  fwd_data,
    output logic         misalign,
    output logic         bus_err,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    output logic [3:0]   dmem_be,
    input  logic         dmem_ack,
    input  logic [31:0]  dmem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic             r_we;
    mem_size_t        r_size;
    logic             r_unsigned;
    logic [31:0]      r_rdata_q;
    logic             r_err;

    logic             w_access;
    logic             w_misaligned;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_val;
    logic             w_stall;
    logic             w_out_valid;
    logic             w_misalign;
    logic             w_bus_err;
    logic             w_kill_wb;

    assign w_access = in_valid & (inflow.mem_ctrl.MemRead | inflow.mem_ctrl.MemWrite);

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = inflow.rs2_data;
        case (inflow.mem_ctrl.MemSize)
            SIZE_B: begin
                w_be    = 4'b0001 << inflow.alu_result[1:0];
                w_wdata = {4{inflow.rs2_data[7:0]}};
            end
            SIZE_H: begin
                w_misaligned = inflow.alu_result[0];
                w_be         = 4'b0011 << inflow.alu_result[1:0];
                w_wdata      = {2{inflow.rs2_data[15:0]}};
            end
            default: begin
                w_misaligned = |inflow.alu_result[1:0];
            end
        endcase
        w_misaligned = w_misaligned & w_access;
    end

    load_align u_load_align (
        .i_rdata    (dmem_rdata),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_val)
    );

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_out_valid = 1'b0;
        w_misalign  = 1'b0;
        w_bus_err   = 1'b0;
        w_kill_wb   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && !w_misaligned) begin
                    w_stall = 1'b1;
                    w_next  = ST_BUSY;
                end else begin
                    w_out_valid = in_valid;
                    w_misalign  = w_misaligned;
                    w_kill_wb   = w_misaligned;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (dmem_ack) begin
                    w_next = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_bus_err = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_kill_wb   = r_err;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rdata_q  <= '0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_size     <= SIZE_B;
            r_unsigned <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (w_access && !w_misaligned) begin
                        r_addr     <= inflow.alu_result;
                        r_wdata    <= w_wdata;
                        r_be       <= w_be;
                        r_we       <= inflow.mem_ctrl.MemWrite;
                        r_size     <= inflow.mem_ctrl.MemSize;
                        r_unsigned <= inflow.mem_ctrl.MemUnsigned;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dmem_ack) begin
                        r_rdata_q <= w_load_val;
                    end
                    if (w_bus_err) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are held inactive while reset is asserted.
    assign stall      = w_stall & ~rst;
    assign out_valid  = w_out_valid & ~rst;
    assign misalign   = w_misalign & ~rst;
    assign bus_err    = w_bus_err & ~rst;
    assign dmem_req   = (r_state == ST_BUSY) & ~rst;
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;

    always_comb begin
        outflow.alu_result = inflow.alu_result;
        outflow.mem_data   = r_rdata_q;
        outflow.pc_incr    = inflow.pc_incr;
        outflow.immediate  = inflow.immediate;
        outflow.rd_addr    = inflow.rd_addr;
        outflow.wb_ctrl    = inflow.wb_ctrl;
        if (w_kill_wb) begin
            outflow.wb_ctrl.RegWrite = 1'b0;
        end
    end

    always_comb begin
        case (inflow.wb_ctrl.MemtoReg)
            MEMTOREG_PC:  fwd_data = inflow.pc_incr;
            MEMTOREG_IMM: fwd_data = inflow.immediate;
            default:      fwd_data = inflow.alu_result;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage with an output
//               scoreboard of expected MEM/WB results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import pipeline_flow_types::*;

    logic         clk = 1'b0;
    logic         rst;
    ex_mem_flow_t inflow;
    logic         in_valid;
    mem_wb_flow_t outflow;
    logic         out_valid;
    logic         stall;
    logic [31:0]  fwd_data;
    logic         misalign;
    logic         bus_err;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inflow     (inflow),
        .in_valid   (in_valid),
        .outflow    (outflow),
        .out_valid  (out_valid),
        .stall      (stall),
        .fwd_data   (fwd_data),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic        chk_mem;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle, then retire a scoreboard entry on out_valid.
    task automatic settle();
        exp_t e;
        #1;
        if (out_valid === 1'b1) begin
            chk("sb_entry_available", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_alu_result", outflow.alu_result, e.alu);
                chk("out_rd_addr", 32'(outflow.rd_addr), 32'(e.rd));
                chk("out_regwrite", 32'(outflow.wb_ctrl.RegWrite), 32'(e.rw));
                if (e.chk_mem) chk("out_mem_data", outflow.mem_data, e.mem);
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [31:0] mem, input logic chk_mem,
                            input logic [4:0] rd, input logic rw);
        exp_t e;
        e.alu = alu; e.mem = mem; e.chk_mem = chk_mem; e.rd = rd; e.rw = rw;
        sb.push_back(e);
    endtask

    task automatic set_instr(input logic [31:0] addr, input logic [31:0] rs2, input logic rd_en,
                             input logic wr_en, input mem_size_t sz, input logic uns,
                             input logic rw, input logic [1:0] mtr, input logic [4:0] rd);
        inflow.alu_result           = addr;
        inflow.rs2_data             = rs2;
        inflow.pc_incr              = 32'h0000_0100;
        inflow.immediate            = 32'h0000_0ABC;
        inflow.rd_addr              = rd;
        inflow.mem_ctrl.MemRead     = rd_en;
        inflow.mem_ctrl.MemWrite    = wr_en;
        inflow.mem_ctrl.MemSize     = sz;
        inflow.mem_ctrl.MemUnsigned = uns;
        inflow.wb_ctrl.RegWrite     = rw;
        inflow.wb_ctrl.MemtoReg     = mtr;
        in_valid                    = 1'b1;
    endtask

    // Runs an aligned access already presented on inflow; acks in BUSY cycle ack_at.
    task automatic mem_access(input int ack_at, input logic [31:0] rd_val, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [3:0] e_be, input logic e_we);
        settle();
        chk("c0_stall", 32'(stall), 32'd1);
        chk("c0_req", 32'(dmem_req), 32'd0);
        chk("c0_out_valid", 32'(out_valid), 32'd0);
        for (int n = 1; n <= ack_at; n++) begin
            tick();
            dmem_rdata = 32'h5A5A_5A5A;
            if (n == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd_val;
            end
            settle();
            chk("busy_req", 32'(dmem_req), 32'd1);
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_addr", dmem_addr, e_addr);
            chk("busy_be", 32'(dmem_be), 32'(e_be));
            chk("busy_we", 32'(dmem_we), 32'(e_we));
            if (e_we) chk("busy_wdata", dmem_wdata, e_wdata);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(dmem_req), 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        chk("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        inflow     = '0;
        tick();
        tick();
        settle();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_rdata_q", outflow.mem_data, 32'd0);
        tick();
        rst = 1'b0;
        settle();

        // ALU op passes through combinationally
        tick();
        set_instr(32'h0000_1234, 32'h0, 1'b0, 1'b0, SIZE_W, 1'b0, 1'b1, MEMTOREG_ALU, 5'd5);
        push_exp(32'h0000_1234, 32'h0, 1'b0, 5'd5, 1'b1);
        settle();
        chk("alu_out_valid", 32'(out_valid), 32'd1);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_fwd", fwd_data, 32'h0000_1234);
        tick();
        in_valid = 1'b0;
        inflow.wb_ctrl.MemtoReg = MEMTOREG_PC;
        settle();
        chk("fwd_pc", fwd_data, 32'h0000_0100);
        inflow.wb_ctrl.MemtoReg = MEMTOREG_IMM;
        settle();
        chk("fwd_imm", fwd_data, 32'h0000_0ABC);

        // Store byte to 0x1003, immediate ack
        tick();
        set_instr(32'h0000_1003, 32'hAABB_CCDD, 1'b0, 1'b1, SIZE_B, 1'b0, 1'b0, MEMTOREG_ALU, 5'd0);
        push_exp(32'h0000_1003, 32'h0, 1'b0, 5'd0, 1'b0);
        mem_access(1, 32'h0, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 1'b1);

        // Load halfword signed/unsigned at 0x2002, ack in third BUSY cycle
        tick();
        set_instr(32'h0000_2002, 32'h0000_1111, 1'b1, 1'b0, SIZE_H, 1'b0, 1'b1, MEMTOREG_MEM, 5'd7);
        push_exp(32'h0000_2002, 32'hFFFF_8001, 1'b1, 5'd7, 1'b1);
        mem_access(3, 32'h8001_0000, 32'h0000_2000, 32'h0, 4'b1100, 1'b0);
        tick();
        set_instr(32'h0000_2002, 32'h0000_1111, 1'b1, 1'b0, SIZE_H, 1'b1, 1'b1, MEMTOREG_MEM, 5'd8);
        push_exp(32'h0000_2002, 32'h0000_8001, 1'b1, 5'd8, 1'b1);
        mem_access(3, 32'h8001_0000, 32'h0000_2000, 32'h0, 4'b1100, 1'b0);

        // Load byte signed at lane 1, store word
        tick();
        set_instr(32'h0000_4001, 32'h0, 1'b1, 1'b0, SIZE_B, 1'b0, 1'b1, MEMTOREG_MEM, 5'd9);
        push_exp(32'h0000_4001, 32'hFFFF_FF80, 1'b1, 5'd9, 1'b1);
        mem_access(2, 32'h1234_80FF, 32'h0000_4000, 32'h0, 4'b0010, 1'b0);
        tick();
        set_instr(32'h0000_5004, 32'hCAFE_F00D, 1'b0, 1'b1, SIZE_W, 1'b0, 1'b0, MEMTOREG_ALU, 5'd0);
        push_exp(32'h0000_5004, 32'h0, 1'b0, 5'd0, 1'b0);
        mem_access(2, 32'h0, 32'h0000_5004, 32'hCAFE_F00D, 4'b1111, 1'b1);

        // Misaligned word load and misaligned halfword store
        tick();
        set_instr(32'h0000_3001, 32'h0, 1'b1, 1'b0, SIZE_W, 1'b0, 1'b1, MEMTOREG_MEM, 5'd10);
        push_exp(32'h0000_3001, 32'h0, 1'b0, 5'd10, 1'b0);
        settle();
        chk("mis_w_pulse", 32'(misalign), 32'd1);
        chk("mis_w_out_valid", 32'(out_valid), 32'd1);
        chk("mis_w_stall", 32'(stall), 32'd0);
        chk("mis_w_req", 32'(dmem_req), 32'd0);
        tick();
        set_instr(32'h0000_3003, 32'h0, 1'b0, 1'b1, SIZE_H, 1'b0, 1'b0, MEMTOREG_ALU, 5'd0);
        push_exp(32'h0000_3003, 32'h0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("mis_h_pulse", 32'(misalign), 32'd1);
        chk("mis_h_stall", 32'(stall), 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        chk("mis_clear", 32'(misalign), 32'd0);
        chk("mis_clear_req", 32'(dmem_req), 32'd0);

        // Timeout: no ack within TIMEOUT=4 BUSY cycles
        tick();
        set_instr(32'h0000_6000, 32'h0, 1'b1, 1'b0, SIZE_W, 1'b0, 1'b1, MEMTOREG_MEM, 5'd11);
        push_exp(32'h0000_6000, 32'h0, 1'b0, 5'd11, 1'b0);
        settle();
        chk("to_c0_stall", 32'(stall), 32'd1);
        for (int n = 1; n <= 4; n++) begin
            tick();
            settle();
            chk("to_busy_req", 32'(dmem_req), 32'd1);
            chk("to_bus_err", 32'(bus_err), 32'(n == 4));
        end
        tick();
        settle();
        chk("to_done_out_valid", 32'(out_valid), 32'd1);
        chk("to_done_req", 32'(dmem_req), 32'd0);
        chk("to_done_bus_err", 32'(bus_err), 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        chk("to_idle_stall", 32'(stall), 32'd0);

        // Reset while BUSY; a late ack must be ignored
        tick();
        set_instr(32'h0000_7000, 32'h0, 1'b1, 1'b0, SIZE_W, 1'b0, 1'b1, MEMTOREG_MEM, 5'd12);
        settle();
        tick();
        settle();
        chk("rb_busy_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        in_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        settle();
        chk("rb_req_dropped", 32'(dmem_req), 32'd0);
        chk("rb_stall", 32'(stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        settle();
        chk("rb_no_out_valid", 32'(out_valid), 32'd0);
        chk("rb_no_req", 32'(dmem_req), 32'd0);
        tick();
        settle();
        chk("rb_no_out_valid2", 32'(out_valid), 32'd0);
        chk("rb_rdata_q_kept", outflow.mem_data, 32'd0);

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
